// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default clocking and the
// bit-period helper that a future transmitter can reuse.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Default board clock and line rate
    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    // Number of system clocks spanned by one serial bit (integer division)
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so an idle-high line can come out of reset already "idle".
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The synchronized line is oversampled by the system clock;
// the start bit is confirmed at its centre and every following bit is sampled
// one bit period later, so all samples land mid-bit. The received byte is only
// published when the stop bit reads high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_serial_in,
    output logic [7:0] o_parallel_out,
    output logic       o_rx_valid,
    output logic       o_frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    rx_state_t        r_state;
    rx_state_t        w_nextState;
    logic [CNT_W-1:0] r_clkCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [7:0]       r_parallelOut;
    logic             r_rxValid;
    logic             r_frameErr;
    logic             w_rxS;
    logic             w_halfDone;
    logic             w_bitDone;
    logic             w_rxValidNext;
    logic             w_frameErrNext;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_serial_in),
        .o_sync (w_rxS)
    );

    assign w_halfDone = (r_clkCnt == HALF_END);
    assign w_bitDone  = (r_clkCnt == BIT_END);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the one-cycle result pulses decided at the stop-bit centre
    always_comb begin
        w_nextState    = r_state;
        w_rxValidNext  = 1'b0;
        w_frameErrNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxS) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (w_halfDone) begin
                    w_nextState = w_rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bitDone && (r_bitIdx == 3'd7)) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    w_nextState    = IDLE;
                    w_rxValidNext  = w_rxS;
                    w_frameErrNext = ~w_rxS;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Bit-period counting, LSB-first shifting and the registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clkCnt      <= '0;
            r_bitIdx      <= '0;
            r_shift       <= '0;
            r_parallelOut <= '0;
            r_rxValid     <= 1'b0;
            r_frameErr    <= 1'b0;
        end else begin
            r_rxValid  <= w_rxValidNext;
            r_frameErr <= w_frameErrNext;
            if (w_rxValidNext) begin
                r_parallelOut <= r_shift;
            end
            case (r_state)
                IDLE: begin
                    r_clkCnt <= '0;
                    r_bitIdx <= '0;
                end
                START: begin
                    r_clkCnt <= w_halfDone ? '0 : r_clkCnt + 1'b1;
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_clkCnt          <= '0;
                        r_shift[r_bitIdx] <= w_rxS;
                        r_bitIdx          <= r_bitIdx + 1'b1;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                STOP: begin
                    r_clkCnt <= w_bitDone ? '0 : r_clkCnt + 1'b1;
                end
                default: begin
                    r_clkCnt <= '0;
                end
            endcase
        end
    end

    assign o_parallel_out = r_parallelOut;
    assign o_rx_valid     = r_rxValid;
    assign o_frame_err    = r_frameErr;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table-driven frames scored against a queue of expected
// receive events, plus hand-written glitch and reset-mid-frame sequences.
module tb_uart_rx;

    localparam int CLKS    = 50_000_000 / 115_200;
    localparam int HALF    = CLKS / 2;
    localparam int LATENCY = 2 + HALF + 9 * CLKS;

    typedef struct {
        logic [7:0] err;
        logic [7:0] data;
    } event_t;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapAfter;
        logic [7:0] expOut;
        logic       expErr;
    } vector_t;

    logic       clk;
    logic       rst;
    logic       serialIn;
    logic [7:0] parallelOut;
    logic       rxValid;
    logic       frameErr;

    int     checks;
    int     failures;
    int     cyc;
    int     frameStartCycle;
    int     lastEventCycle;
    event_t sbQ[$];

    uart_rx dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_serial_in   (serialIn),
        .o_parallel_out(parallelOut),
        .o_rx_valid    (rxValid),
        .o_frame_err   (frameErr)
    );

    // 50 MHz clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Free-running cycle index used for latency measurement
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic holdCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; a low stop bit is held only past its centre so the line recovers cleanly
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        frameStartCycle = cyc;
        serialIn = 1'b0;
        holdCycles(CLKS);
        for (int b = 0; b < 8; b++) begin
            serialIn = data[b];
            holdCycles(CLKS);
        end
        serialIn = stopBit;
        holdCycles(stopBit ? CLKS : (CLKS * 3) / 4);
        serialIn = 1'b1;
    endtask

    // Scoreboard: every result pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst) begin
            if (rxValid && frameErr) begin
                checks++;
                failures++;
                $display("[TB] FAIL bothPulses actual=11 required=not both");
            end
            if (rxValid || frameErr) begin
                lastEventCycle = cyc;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedEvent actual=valid%0b/err%0b data=%0h required=none",
                             rxValid, frameErr, parallelOut);
                end else begin
                    event_t exp;
                    exp = sbQ.pop_front();
                    checkOutput("eventIsErr", {31'd0, frameErr}, {24'd0, exp.err});
                    checkOutput("eventData", {24'd0, parallelOut}, {24'd0, exp.data});
                end
            end
        end
    end

    // Main sequence
    initial begin
        vector_t vecs[4];
        checks   = 0;
        failures = 0;
        lastEventCycle = 0;

        vecs[0] = '{data: 8'hAA, stopBit: 1'b1, gapAfter: 1,    expOut: 8'hAA, expErr: 1'b0};
        vecs[1] = '{data: 8'hFF, stopBit: 1'b1, gapAfter: CLKS, expOut: 8'hFF, expErr: 1'b0};
        vecs[2] = '{data: 8'h55, stopBit: 1'b0, gapAfter: CLKS, expOut: 8'hFF, expErr: 1'b1};
        vecs[3] = '{data: 8'h3C, stopBit: 1'b1, gapAfter: CLKS, expOut: 8'h3C, expErr: 1'b0};

        rst      = 1'b1;
        serialIn = 1'b1;
        holdCycles(50);
        rst = 1'b0;
        holdCycles(1);
        checkOutput("resetOut", {24'd0, parallelOut}, 32'h00);
        checkOutput("resetValid", {31'd0, rxValid}, 32'd0);
        checkOutput("resetErr", {31'd0, frameErr}, 32'd0);
        holdCycles(5000);
        checkOutput("idleOut", {24'd0, parallelOut}, 32'h00);

        for (int i = 0; i < 4; i++) begin
            sbQ.push_back('{err: {7'd0, vecs[i].expErr}, data: vecs[i].expOut});
            applyStimulus(vecs[i].data, vecs[i].stopBit);
            checkOutput($sformatf("vec%0dDone", i), sbQ.size(), 32'd0);
            if (i == 0) begin
                checks++;
                if ((lastEventCycle - frameStartCycle < LATENCY - 2) ||
                    (lastEventCycle - frameStartCycle > LATENCY + 2)) begin
                    failures++;
                    $display("[TB] FAIL latency actual=%0d required=%0d+-2",
                             lastEventCycle - frameStartCycle, LATENCY);
                end
            end
            holdCycles(vecs[i].gapAfter);
            checkOutput($sformatf("vec%0dOut", i), {24'd0, parallelOut}, {24'd0, vecs[i].expOut});
        end

        // Short low glitch must be rejected and the receiver ready again by HALF+3 cycles
        serialIn = 1'b0;
        holdCycles(100);
        serialIn = 1'b1;
        holdCycles(HALF + 3 - 100);
        checkOutput("glitchOut", {24'd0, parallelOut}, 32'h3C);
        sbQ.push_back('{err: 8'd0, data: 8'hA5});
        applyStimulus(8'hA5, 1'b1);
        checkOutput("afterGlitchDone", sbQ.size(), 32'd0);
        holdCycles(CLKS);
        checkOutput("afterGlitchOut", {24'd0, parallelOut}, 32'hA5);

        // Reset during data bit 4 of 8'hC3 discards the partial byte
        serialIn = 1'b0;
        holdCycles(CLKS);
        for (int b = 0; b < 4; b++) begin
            serialIn = ((8'hC3 >> b) & 8'h01) != 8'h00;
            holdCycles(CLKS);
        end
        serialIn = 1'b0;
        holdCycles(200);
        rst      = 1'b1;
        serialIn = 1'b1;
        holdCycles(5);
        rst = 1'b0;
        holdCycles(CLKS);
        checkOutput("midResetOut", {24'd0, parallelOut}, 32'h00);
        checkOutput("midResetValid", {31'd0, rxValid}, 32'd0);
        sbQ.push_back('{err: 8'd0, data: 8'h81});
        applyStimulus(8'h81, 1'b1);
        checkOutput("afterResetDone", sbQ.size(), 32'd0);
        holdCycles(CLKS);
        checkOutput("afterResetOut", {24'd0, parallelOut}, 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
